// File: rtl/rw_arb_pkg.sv
// rtl/rw_arb_pkg.sv - shared types and constants for rw_port_arbiter
package rw_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/rw_port_arbiter_rr_pick.sv
// rtl/rw_port_arbiter_rr_pick.sv - round-robin first-set search starting at ptr
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  always_comb begin
    int k;
    any    = 1'b0;
    onehot = '0;
    idx    = '0;
    k      = 0;
    for (int i = 0; i < N; i++) begin
      // offset from ptr, wrapped without a modulo so non-power-of-two N works
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any && req[IW'(k)]) begin
        any             = 1'b1;
        onehot[IW'(k)]  = 1'b1;
        idx             = IW'(k);
      end
    end
  end

endmodule

// File: rtl/rw_port_arbiter.sv
// rtl/rw_port_arbiter.sv - shares one memory-port master among NUM_REQ requesters
module rw_port_arbiter
  import rw_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int RW_DATA_WIDTH = 64,
  parameter int RW_ADDR_WIDTH = 64,
  parameter int AXI_ID_WIDTH  = 4,
  parameter int TIMEOUT       = DEFAULT_TIMEOUT
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    req_cen_i,
  input  logic [NUM_REQ-1:0]                    req_wen_i,
  input  logic [NUM_REQ*RW_ADDR_WIDTH-1:0]      req_addr_i,
  input  logic [NUM_REQ*3-1:0]                  req_size_i,
  input  logic [NUM_REQ*8-1:0]                  req_len_i,
  input  logic [NUM_REQ*AXI_ID_WIDTH-1:0]       req_id_i,
  input  logic [NUM_REQ*RW_DATA_WIDTH-1:0]      req_wdata_i,
  input  logic [NUM_REQ*RW_DATA_WIDTH/8-1:0]    req_wmask_i,
  output logic [NUM_REQ-1:0]                    req_ready_o,
  output logic [NUM_REQ-1:0]                    req_rvalid_o,
  output logic [NUM_REQ-1:0]                    req_wbeat_o,
  output logic [RW_DATA_WIDTH-1:0]              req_rdata_o,
  output logic [1:0]                            req_resp_o,
  output logic                                  m_cen_o,
  output logic                                  m_wen_o,
  output logic [RW_ADDR_WIDTH-1:0]              m_addr_o,
  output logic [2:0]                            m_size_o,
  output logic [7:0]                            m_len_o,
  output logic [AXI_ID_WIDTH-1:0]               m_id_o,
  output logic [RW_DATA_WIDTH-1:0]              m_wdata_o,
  output logic [RW_DATA_WIDTH/8-1:0]            m_wmask_o,
  input  logic                                  m_ready_i,
  input  logic                                  m_rvalid_i,
  input  logic [RW_DATA_WIDTH-1:0]              m_rdata_i,
  input  logic [1:0]                            m_resp_i,
  input  logic                                  m_wbeat_i,
  output logic [NUM_REQ-1:0]                    grant_o,
  output logic                                  timeout_o
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int MW = RW_DATA_WIDTH / 8;
  localparam logic [15:0] TO_VAL = 16'(TIMEOUT);

  arb_state_e         state, state_nxt;
  logic [NUM_REQ-1:0] grant_q, pick_onehot;
  logic [PW-1:0]      gidx_q, ptr_q, pick_idx;
  logic               pick_any;
  logic [15:0]        wd_cnt;
  logic               timeout_q;

  rr_pick #(.N(NUM_REQ), .IW(PW)) u_pick (
    .req    (req_cen_i),
    .ptr    (ptr_q),
    .any    (pick_any),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any)  state_nxt = BUSY;
      BUSY:    if (m_ready_i) state_nxt = DRAIN;
      DRAIN:                  state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE && pick_any) begin
        grant_q <= pick_onehot;
        gidx_q  <= pick_idx;
        ptr_q   <= (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        wd_cnt  <= '0;
      end else if (state == DRAIN) begin
        grant_q <= '0;
      end
      // watchdog only observes; a stuck transaction is flagged, never aborted
      if (state == BUSY) begin
        if (wd_cnt != 16'hFFFF) wd_cnt <= wd_cnt + 16'd1;
        if (wd_cnt + 16'd1 == TO_VAL) timeout_q <= 1'b1;
      end
    end
  end

  always_comb begin
    int sel;
    sel          = int'(gidx_q);
    m_cen_o      = 1'b0;
    m_wen_o      = 1'b0;
    m_addr_o     = '0;
    m_size_o     = '0;
    m_len_o      = '0;
    m_id_o       = '0;
    m_wdata_o    = '0;
    m_wmask_o    = '0;
    req_ready_o  = '0;
    req_rvalid_o = '0;
    req_wbeat_o  = '0;
    req_rdata_o  = '0;
    req_resp_o   = '0;
    // DRAIN keeps the request asserted so the master can leave its DONE state
    if (state != IDLE) begin
      m_cen_o   = 1'b1;
      m_wen_o   = req_wen_i[sel];
      m_addr_o  = req_addr_i[sel*RW_ADDR_WIDTH +: RW_ADDR_WIDTH];
      m_size_o  = req_size_i[sel*3 +: 3];
      m_len_o   = req_len_i[sel*8 +: 8];
      m_id_o    = req_id_i[sel*AXI_ID_WIDTH +: AXI_ID_WIDTH];
      m_wdata_o = req_wdata_i[sel*RW_DATA_WIDTH +: RW_DATA_WIDTH];
      m_wmask_o = req_wmask_i[sel*MW +: MW];
    end
    if (state == BUSY) begin
      req_ready_o  = {NUM_REQ{m_ready_i}} & grant_q;
      req_rvalid_o = {NUM_REQ{m_rvalid_i}} & grant_q;
      req_wbeat_o  = {NUM_REQ{m_wbeat_i}} & grant_q;
      req_rdata_o  = m_rdata_i;
      req_resp_o   = m_resp_i;
    end
  end

  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rw_port_arbiter.sv
// tb/tb_rw_port_arbiter.sv - randomized self-checking bench for rw_port_arbiter
module tb_rw_port_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int AW = 64;
  localparam int IW = 4;
  localparam int TO = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]      req_cen, req_wen, req_ready, req_rvalid, req_wbeat, grant;
  logic [N*AW-1:0]   req_addr;
  logic [N*3-1:0]    req_size;
  logic [N*8-1:0]    req_len;
  logic [N*IW-1:0]   req_id;
  logic [N*DW-1:0]   req_wdata;
  logic [N*DW/8-1:0] req_wmask;
  logic [DW-1:0]     req_rdata, m_wdata, m_rdata;
  logic [1:0]        req_resp, m_resp;
  logic              m_cen, m_wen, m_ready, m_rvalid, m_wbeat, timeout;
  logic [AW-1:0]     m_addr;
  logic [2:0]        m_size;
  logic [7:0]        m_len;
  logic [IW-1:0]     m_id;
  logic [DW/8-1:0]   m_wmask;

  rw_port_arbiter #(
    .NUM_REQ(N), .RW_DATA_WIDTH(DW), .RW_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_cen_i(req_cen), .req_wen_i(req_wen), .req_addr_i(req_addr), .req_size_i(req_size),
    .req_len_i(req_len), .req_id_i(req_id), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
    .req_ready_o(req_ready), .req_rvalid_o(req_rvalid), .req_wbeat_o(req_wbeat),
    .req_rdata_o(req_rdata), .req_resp_o(req_resp),
    .m_cen_o(m_cen), .m_wen_o(m_wen), .m_addr_o(m_addr), .m_size_o(m_size), .m_len_o(m_len),
    .m_id_o(m_id), .m_wdata_o(m_wdata), .m_wmask_o(m_wmask),
    .m_ready_i(m_ready), .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata), .m_resp_i(m_resp),
    .m_wbeat_i(m_wbeat), .grant_o(grant), .timeout_o(timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h required %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: ms 0=no owner, 1=transaction open, 2=completion handshake cycle
  int ms = 0, mo = 0, mptr = 0, mcnt = 0;
  bit mto = 1'b0;

  // observation statistics for the directed scenarios
  int rv_cnt[N], wb_cnt[N], rd_cnt[N];
  int rv3_early, hi_run, lo_run, hi_last, to_at;
  bit prev_cen, prev_to, seen_rise;
  logic [N-1:0] order_q[$];
  int gap_q[$];

  logic [N-1:0] sv_ready;
  logic sv_cen, sv_wen;
  logic [7:0] sv_len;

  always @(negedge clk) begin
    logic [N-1:0] eg;
    bit act, found;
    if (!rst_n) begin
      ms = 0; mptr = 0; mcnt = 0; mto = 1'b0;
    end
    act = (ms != 0);
    eg = '0;
    if (act) eg[mo] = 1'b1;
    check("grant", grant, eg);
    check("m_cen", m_cen, act);
    check("ready", req_ready, (ms == 1 && m_ready) ? eg : '0);
    check("rvalid", req_rvalid, (ms == 1 && m_rvalid) ? eg : '0);
    check("wbeat", req_wbeat, (ms == 1 && m_wbeat) ? eg : '0);
    check("timeout", timeout, mto);
    if (act) begin
      check("m_addr", m_addr, req_addr[mo*AW +: AW]);
      check("m_len", m_len, req_len[mo*8 +: 8]);
      check("m_wen", m_wen, req_wen[mo]);
      check("m_id", m_id, req_id[mo*IW +: IW]);
      check("m_wdata", m_wdata, req_wdata[mo*DW +: DW]);
    end
    if (ms == 1) check("rdata", req_rdata, m_rdata);

    for (int k = 0; k < N; k++) begin
      rv_cnt[k] += int'(req_rvalid[k]);
      wb_cnt[k] += int'(req_wbeat[k]);
      rd_cnt[k] += int'(req_ready[k]);
    end
    if (req_rvalid[3] && !grant[3]) rv3_early++;
    if (m_cen) begin
      if (!prev_cen) begin
        order_q.push_back(grant);
        if (seen_rise) gap_q.push_back(lo_run);
        seen_rise = 1'b1;
        hi_run = 0;
      end
      hi_run++;
    end else begin
      if (prev_cen) begin hi_last = hi_run; lo_run = 0; end
      lo_run++;
    end
    if (timeout && !prev_to) to_at = hi_run;
    prev_cen = m_cen;
    prev_to  = timeout;
    sv_ready = req_ready;
    sv_cen   = m_cen;
    sv_wen   = m_wen;
    sv_len   = m_len;

    if (rst_n) begin
      case (ms)
        0: if (|req_cen) begin
             found = 1'b0;
             for (int i = 0; i < N; i++)
               if (!found && req_cen[(mptr + i) % N]) begin
                 found = 1'b1;
                 mo = (mptr + i) % N;
               end
             mptr = (mo + 1) % N;
             mcnt = 0;
             ms = 1;
           end
        1: begin
             mcnt++;
             if (mcnt >= TO) mto = 1'b1;
             if (m_ready) ms = 2;
           end
        default: ms = 0;
      endcase
    end
  end

  // stimulus knobs
  logic [N-1:0] want = '0;
  logic [N-1:0] active = '0;
  int len_cfg[N], wen_cfg[N];
  int extra = 0, p_req = 100, s_cnt = 0;
  bit glitch = 1'b0, s_done = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (active[k] && sv_ready[k]) active[k] = 1'b0;
      if (!active[k] && want[k] && ($urandom_range(99) < p_req)) begin
        active[k] = 1'b1;
        req_addr[k*AW +: AW] = {$urandom, $urandom};
        req_size[k*3 +: 3]   = 3'($urandom);
        req_id[k*IW +: IW]   = IW'($urandom);
        req_len[k*8 +: 8]    = (len_cfg[k] < 0) ? 8'($urandom_range(7)) : 8'(len_cfg[k]);
        req_wen[k]           = (wen_cfg[k] < 0) ? 1'($urandom) : 1'(wen_cfg[k]);
      end
    end
    req_cen = active;
    for (int w = 0; w < N*DW/32; w++) req_wdata[w*32 +: 32] = $urandom;
    req_wmask = $urandom;
    // simple master model: a beat per cycle, completion 'extra' cycles after the last beat
    if (!sv_cen) begin s_cnt = 0; s_done = 1'b0; end
    m_ready = 1'b0; m_rvalid = 1'b0; m_wbeat = 1'b0;
    m_rdata = {$urandom, $urandom};
    m_resp  = 2'($urandom);
    if (sv_cen && !s_done) begin
      s_cnt++;
      if (s_cnt <= int'(sv_len) + 1) begin
        if (sv_wen) m_wbeat = 1'b1;
        else        m_rvalid = 1'b1;
      end
      if (s_cnt == int'(sv_len) + 1 + extra) begin m_ready = 1'b1; s_done = 1'b1; end
    end else if (glitch) begin
      m_ready = 1'($urandom); m_rvalid = 1'($urandom); m_wbeat = 1'($urandom);
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < N; k++) begin rv_cnt[k] = 0; wb_cnt[k] = 0; rd_cnt[k] = 0; end
    rv3_early = 0; hi_last = 0; to_at = 0; seen_rise = 1'b0;
    order_q.delete();
    gap_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    want = '0; active = '0; req_cen = '0;
    glitch = 1'b0; extra = 0; p_req = 100;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  logic [N-1:0] exp_order[5];

  initial begin
    req_cen = '0; req_wen = '0; req_addr = '0; req_size = '0; req_len = '0;
    req_id = '0; req_wdata = '0; req_wmask = '0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_wbeat = 1'b0; m_rdata = '0; m_resp = '0;
    for (int k = 0; k < N; k++) begin len_cfg[k] = -1; wen_cfg[k] = -1; end
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    check("reset_grant", grant, '0);
    check("reset_cen", m_cen, 1'b0);
    check("reset_timeout", timeout, 1'b0);

    // all four requesting continuously with single-beat writes
    clear_stats();
    for (int k = 0; k < N; k++) begin len_cfg[k] = 0; wen_cfg[k] = 1; end
    want = 4'hF;
    for (int i = 0; i < 200 && order_q.size() < 5; i++) step();
    want = '0;
    repeat (30) step();
    check("rr_rises", order_q.size() >= 5, 1'b1);
    if (order_q.size() >= 5)
      for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), order_q[i], exp_order[i]);
    if (gap_q.size() >= 4)
      for (int i = 0; i < 4; i++) check($sformatf("rr_gap%0d", i), gap_q[i], 1);

    // single read from requester 2, four beats
    do_reset();
    clear_stats();
    len_cfg[2] = 3; wen_cfg[2] = 0;
    want = 4'b0100;
    step();
    want = '0;
    repeat (20) step();
    check("rd_beats2", rv_cnt[2], 4);
    check("rd_ready2", rd_cnt[2], 1);
    check("rd_hi_run", hi_last, 6);
    check("rd_others", rv_cnt[0] + rv_cnt[1] + rv_cnt[3], 0);

    // long write from 1 while 3 waits with a read
    do_reset();
    clear_stats();
    len_cfg[1] = 7; wen_cfg[1] = 1; len_cfg[3] = 3; wen_cfg[3] = 0;
    want = 4'b1010;
    step();
    want = '0;
    repeat (40) step();
    check("wr_beats1", wb_cnt[1], 8);
    check("rd_beats3", rv_cnt[3], 4);
    check("rv3_early", rv3_early, 0);
    check("wr_ready", rd_cnt[1] + rd_cnt[3], 2);

    // completion withheld past the watchdog limit
    do_reset();
    clear_stats();
    len_cfg[0] = 0; wen_cfg[0] = 0; extra = 1100;
    want = 4'b0001;
    step();
    want = '0;
    repeat (1150) step();
    extra = 0;
    repeat (5) step();
    check("to_rise_cycle", to_at, TO + 1);
    check("to_sticky", timeout, 1'b1);
    check("to_ready", rd_cnt[0], 1);

    // reset in the middle of requester 0's transaction, requester 1 pending
    do_reset();
    clear_stats();
    len_cfg[0] = 0; wen_cfg[0] = 0; len_cfg[1] = 0; wen_cfg[1] = 1; extra = 50;
    want = 4'b0001;
    step();
    want = '0;
    repeat (5) step();
    want = 4'b0010;
    step();
    want = '0;
    repeat (2) step();
    rst_n = 1'b0;
    active[0] = 1'b0;
    req_cen = active;
    #1;
    check("rst_mid_cen", m_cen, 1'b0);
    check("rst_mid_grant", grant, '0);
    check("rst_mid_ready", req_ready, '0);
    step();
    extra = 0;
    clear_stats();
    rst_n = 1'b1;
    for (int i = 0; i < 50 && order_q.size() == 0; i++) step();
    check("rst_first_grant", (order_q.size() > 0) ? order_q[0] : '0, 4'b0010);
    repeat (10) step();

    // completion glitches with nobody owning the port
    do_reset();
    clear_stats();
    glitch = 1'b1;
    repeat (30) step();
    glitch = 1'b0;
    check("glitch_ready", rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3], 0);
    check("glitch_rises", order_q.size(), 0);

    // randomized traffic
    do_reset();
    for (int blk = 0; blk < 60; blk++) begin
      want   = N'($urandom);
      glitch = 1'($urandom);
      extra  = $urandom_range(3);
      p_req  = 30;
      for (int k = 0; k < N; k++) begin len_cfg[k] = -1; wen_cfg[k] = -1; end
      repeat (50) step();
    end
    want = '0;
    glitch = 1'b0;
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
